// File: rtl/montre_de1_jtag_pkg.sv
// Shared types and constants for the virtual-JTAG debug initiator.
// Optional feature macro used by the top: MONTRE_DE1_JTAG_IR_SKIP_EN.
package montre_de1_jtag_pkg;

    localparam int unsigned TCK_DIV_DEF  = 2;
    localparam int unsigned DR_WIDTH_DEF = 38;
    localparam int unsigned IR_WIDTH_DEF = 2;
    localparam int unsigned BIT_CNT_W    = 6;
    localparam int unsigned TCK_CNT_W    = 8;

    // Debug-module virtual instruction encodings
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RTI,
        ST_RSP
    } state_e;

    // TCK runs only while a virtual JTAG state is being presented
    function automatic logic tck_active(input state_e s);
        return (s != ST_IDLE) && (s != ST_RSP);
    endfunction

endpackage

// File: rtl/montre_de1_jtag_tck_gen.sv
// Divided TCK generator: TCK toggles every TCK_DIV clk cycles while enabled,
// parked low (counter cleared) while disabled.
module montre_de1_jtag_tck_gen
    import montre_de1_jtag_pkg::*;
#(
    parameter int unsigned TCK_DIV = TCK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic tck_rise_c,
    output logic tck_fall_c
);

    logic [TCK_CNT_W-1:0] cnt;
    logic                 wrap_c;

    assign wrap_c     = en && (cnt == TCK_CNT_W'(TCK_DIV - 1));
    assign tck_rise_c = wrap_c && !tck;
    assign tck_fall_c = wrap_c && tck;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (wrap_c) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + TCK_CNT_W'(1);
        end
    end

endmodule

// File: rtl/montre_de1_jtag_debug_initiator.sv
// Host end of the vji protocol: runs UIR/CDR/SDR/UDR/RTI per command and returns TDO.
// Define MONTRE_DE1_JTAG_IR_SKIP_EN to skip UIR when the IR matches the last one issued.
module montre_de1_jtag_debug_initiator
    import montre_de1_jtag_pkg::*;
#(
    parameter int unsigned TCK_DIV  = TCK_DIV_DEF,
    parameter int unsigned DR_WIDTH = DR_WIDTH_DEF,
    parameter int unsigned IR_WIDTH = IR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    state_e                 state;
    logic [DR_WIDTH-1:0]    shift_q;
    logic [DR_WIDTH-1:0]    cap_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   tck_en_c;
    logic                   tck_rise_c;
    logic                   tck_fall_c;
    logic                   accept_c;
    logic                   skip_c;

    assign tck_en_c = tck_active(state);
    assign accept_c = (state == ST_IDLE) && cmd_valid && cmd_ready;

    montre_de1_jtag_tck_gen #(
        .TCK_DIV    (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset      (reset),
        .en         (tck_en_c),
        .tck        (vji_tck),
        .tck_rise_c (tck_rise_c),
        .tck_fall_c (tck_fall_c)
    );

`ifdef MONTRE_DE1_JTAG_IR_SKIP_EN
    logic [IR_WIDTH-1:0] ir_cache;
    logic                ir_cache_vld;

    assign skip_c = ir_cache_vld && (cmd_ir == ir_cache);

    // Remembers the IR most recently presented to the debug module
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_cache     <= '0;
            ir_cache_vld <= 1'b0;
        end else if (accept_c) begin
            ir_cache     <= cmd_ir;
            ir_cache_vld <= 1'b1;
        end
    end
`else
    assign skip_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
            vji_uir   <= 1'b0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_udr   <= 1'b0;
            vji_rti   <= 1'b0;
            shift_q   <= '0;
            cap_q     <= '0;
            bit_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept_c) begin
                        cmd_ready <= 1'b0;
                        shift_q   <= cmd_data;
                        vji_ir_in <= cmd_ir;
                        bit_cnt   <= '0;
                        if (skip_c) begin
                            state   <= ST_CDR;
                            vji_cdr <= 1'b1;
                        end else begin
                            state   <= ST_UIR;
                            vji_uir <= 1'b1;
                        end
                    end
                end
                ST_UIR: begin
                    if (tck_fall_c) begin
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                        state   <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (tck_fall_c) begin
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= shift_q[0];
                        state   <= ST_SDR;
                    end
                end
                ST_SDR: begin
                    if (tck_rise_c) begin
                        cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
                    end
                    // Shift on the falling edge; the last bit's falling edge ends the scan
                    if (tck_fall_c) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == BIT_CNT_W'(DR_WIDTH - 1)) begin
                            vji_sdr <= 1'b0;
                            vji_tdi <= 1'b0;
                            vji_udr <= 1'b1;
                            state   <= ST_UDR;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            vji_tdi <= shift_q[1];
                        end
                    end
                end
                ST_UDR: begin
                    if (tck_fall_c) begin
                        vji_udr <= 1'b0;
                        vji_rti <= 1'b1;
                        state   <= ST_RTI;
                    end
                end
                ST_RTI: begin
                    if (tck_fall_c) begin
                        vji_rti   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap_q;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montre_de1_jtag_debug_initiator.sv
// Self-checking bench: directed and random commands against a transaction-level model.
module tb_montre_de1_jtag_debug_initiator;
    import montre_de1_jtag_pkg::*;

    localparam int unsigned D   = 2;
    localparam int unsigned W   = 38;
    localparam int unsigned IRW = 2;
`ifdef MONTRE_DE1_JTAG_IR_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir = '0;
    logic [W-1:0]   cmd_data = '0;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           vji_tck, vji_tdi;
    logic           vji_tdo = 1'b0;
    logic [IRW-1:0] vji_ir_in;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    always #5 clk = ~clk;

    montre_de1_jtag_debug_initiator #(
        .TCK_DIV(D), .DR_WIDTH(W), .IR_WIDTH(IRW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    int n_pass = 0;
    int n_total = 0;

    // Observation state, all owned by the single stimulus process
    int         cyc = 0;
    int         acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_cyc = 0, uir_cnt = 0, sr_idx = 0;
    int         acc_q[$];
    logic       tdi_log[$];
    logic [W-1:0] rsp_dat = '0;
    logic [IRW-1:0] uir_ir = '0;
    logic       prev_tck = 1'b0, prev_tdi = 1'b0, prev_sdr = 1'b0, prev_uir = 1'b0;
    bit         in_txn = 1'b0;
    bit         mode_lb = 1'b1;
    logic [W-1:0] sr_bits = '0;

    // Reference model of the IR cache
    logic [IRW-1:0] m_ir = '0;
    bit             m_vld = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_latency(input bit with_uir);
        return 1 + 2 * int'(D) * (int'(W) + 3 + (with_uir ? 1 : 0));
    endfunction

    function automatic bit model_uir(input logic [IRW-1:0] ir);
        return !(SKIP_EN && m_vld && (ir == m_ir));
    endfunction

    task automatic model_issue(input logic [IRW-1:0] ir);
        m_ir  = ir;
        m_vld = 1'b1;
    endtask

    // One clk cycle: per-cycle invariants, event logging and the TDO responder
    task automatic tick();
        logic acc;
        logic ok;
        acc = cmd_valid && cmd_ready && !reset;
        @(negedge clk);
        cyc++;
        if (reset) in_txn = 1'b0;
        if (acc) begin
            acc_cnt++;
            acc_cyc = cyc - 1;
            acc_q.push_back(cyc - 1);
            in_txn = 1'b1;
        end
        if (in_txn) chk("ready_low_in_txn", 64'(cmd_ready), 64'd0);
        ok = ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) <= 1);
        chk("flags_onehot", 64'(ok), 64'd1);
        ok = !(cmd_ready && vji_tck);
        chk("tck_low_idle", 64'(ok), 64'd1);
        ok = (vji_tdi === prev_tdi) || (prev_tck && !vji_tck) || reset;
        chk("tdi_on_fall", 64'(ok), 64'd1);
        ok = vji_sdr || !vji_tdi;
        chk("tdi_zero_outside_sdr", 64'(ok), 64'd1);
        if (vji_uir && !prev_uir) begin
            uir_cnt++;
            uir_ir = vji_ir_in;
        end
        if (vji_sdr && !prev_sdr) begin
            tdi_log.delete();
            if (mode_lb) vji_tdo = 1'b0;
            else begin
                vji_tdo = sr_bits[0];
                sr_idx  = 1;
            end
        end else if (vji_sdr && !prev_tck && vji_tck) begin
            tdi_log.push_back(vji_tdi);
            if (mode_lb) vji_tdo = vji_tdi;
            else if (sr_idx < int'(W)) begin
                vji_tdo = sr_bits[sr_idx];
                sr_idx++;
            end
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_dat = rsp_data;
            in_txn  = 1'b0;
        end
        prev_tck = vji_tck;
        prev_tdi = vji_tdi;
        prev_sdr = vji_sdr;
        prev_uir = vji_uir;
    endtask

    task automatic wait_ready();
        int budget = 0;
        while (!cmd_ready && budget < 400) begin
            tick();
            budget++;
        end
        chk("ready_wait", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_cmd(input logic [IRW-1:0] ir, input logic [W-1:0] data,
                           input bit lb, input logic [W-1:0] sr, output logic [W-1:0] tdi_val);
        int u0, r0, budget;
        bit eu;
        logic [W-1:0] exp_rsp;
        mode_lb = lb;
        sr_bits = sr;
        wait_ready();
        eu = model_uir(ir);
        model_issue(ir);
        cmd_ir = ir;
        cmd_data = data;
        cmd_valid = 1'b1;
        u0 = uir_cnt;
        r0 = rsp_cnt;
        tick();
        cmd_valid = 1'b0;
        budget = 0;
        while (rsp_cnt == r0 && budget < 1000) begin
            tick();
            budget++;
        end
        chk("rsp_seen", 64'(rsp_cnt - r0), 64'd1);
        chk("latency", 64'(rsp_cyc - acc_cyc), 64'(exp_latency(eu)));
        chk("uir_count", 64'(uir_cnt - u0), 64'(eu));
        if (eu) chk("uir_ir", 64'(uir_ir), 64'(ir));
        chk("ir_in_hold", 64'(vji_ir_in), 64'(ir));
        chk("sdr_periods", 64'(tdi_log.size()), 64'(W));
        tdi_val = '0;
        for (int i = 0; i < tdi_log.size() && i < int'(W); i++) tdi_val[i] = tdi_log[i];
        chk("tdi_sequence", 64'(tdi_val), 64'(data));
        exp_rsp = lb ? (data << 1) : sr;
        chk("rsp_data", 64'(rsp_dat), 64'(exp_rsp));
        for (int i = 0; i < 3; i++) tick();
        chk("single_pulse", 64'(rsp_cnt - r0), 64'd1);
        chk("rsp_data_hold", 64'(rsp_data), 64'(exp_rsp));
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    initial begin : stim
        logic [W-1:0] tv;
        logic [W-1:0] d;
        logic [IRW-1:0] irs[3];
        bit eus[3];
        int a0, r0, k, budget;
        logic [48:0] all_out;

        // Reset state
        for (int i = 0; i < 5; i++) tick();
        all_out = {cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
                   vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        chk("reset_outputs", 64'(all_out), 64'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Directed loopback command
        run_cmd(IR_BREAK, 38'h2A_5A5A_5A5A, 1'b1, '0, tv);
        chk("tdi_first8", 64'(tv[7:0]), 64'h5A);

        // Stub responder with a fixed sr
        run_cmd(IR_TRACEMEM, rnd_word(), 1'b0, 38'h3F_0000_0001, tv);

        // Random commands and responder contents
        for (int i = 0; i < 4; i++) begin
            run_cmd(IRW'($urandom_range(0, 3)), rnd_word(), 1'($urandom_range(0, 1)), rnd_word(), tv);
        end

        // Back-to-back with cmd_valid held high
        irs[0] = IR_TRACECTRL;
        irs[1] = IR_OCIMEM;
        irs[2] = IR_TRACECTRL;
        mode_lb = 1'b1;
        wait_ready();
        a0 = acc_cnt;
        r0 = rsp_cnt;
        acc_q.delete();
        k = 0;
        d = rnd_word();
        cmd_ir = irs[0];
        cmd_data = d;
        eus[0] = model_uir(irs[0]);
        model_issue(irs[0]);
        cmd_valid = 1'b1;
        budget = 0;
        while (acc_cnt - a0 < 3 && budget < 1000) begin
            tick();
            budget++;
            if (acc_cnt - a0 == k + 1) begin
                k++;
                if (k < 3) begin
                    d = rnd_word();
                    cmd_ir = irs[k];
                    cmd_data = d;
                    eus[k] = model_uir(irs[k]);
                    model_issue(irs[k]);
                end
            end
        end
        cmd_valid = 1'b0;
        budget = 0;
        while (rsp_cnt - r0 < 3 && budget < 1000) begin
            tick();
            budget++;
        end
        chk("b2b_accepts", 64'(acc_q.size()), 64'd3);
        chk("b2b_rsps", 64'(rsp_cnt - r0), 64'd3);
        if (acc_q.size() == 3) begin
            chk("b2b_spacing0", 64'(acc_q[1] - acc_q[0]), 64'(exp_latency(eus[0]) + 1));
            chk("b2b_spacing1", 64'(acc_q[2] - acc_q[1]), 64'(exp_latency(eus[1]) + 1));
        end
        chk("b2b_last_rsp", 64'(rsp_dat), 64'(d << 1));

        // Reset in the middle of SDR (after bit 10)
        mode_lb = 1'b1;
        wait_ready();
        cmd_ir = IR_OCIMEM;
        cmd_data = rnd_word();
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        r0 = rsp_cnt;
        budget = 0;
        while (!(vji_sdr && tdi_log.size() >= 10) && budget < 1000) begin
            tick();
            budget++;
        end
        chk("reached_sdr_bit10", 64'(vji_sdr), 64'd1);
        reset = 1'b1;
        tick();
        all_out = {cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
                   vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        chk("abort_outputs", 64'(all_out), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        m_vld = 1'b0;
        tick();
        tick();
        chk("ready_after_abort", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 200; i++) tick();
        chk("no_rsp_after_abort", 64'(rsp_cnt - r0), 64'd0);

        // IR reuse, then a different IR
        run_cmd(IR_TRACEMEM, rnd_word(), 1'b1, '0, tv);
        run_cmd(IR_TRACEMEM, rnd_word(), 1'b0, rnd_word(), tv);
        run_cmd(IR_OCIMEM, rnd_word(), 1'b1, '0, tv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/montre_de1_jtag_debug_initiator.md
Name: montre_de1_jtag_debug_initiator

Overview:
- Drives the virtual-JTAG side of the CPU JTAG debug module: the initiator/host end of the vji protocol that the debug module responds to.
- Accepts one debug command at a time (2-bit instruction + 38-bit DR payload) from an on-chip controller and generates the UIR/CDR/SDR/UDR/RTI sequence on a divided TCK.
- Captures the TDO stream (the debug module's shifted-out sr) and returns it as a response word.
- Used for on-chip self-debug and bench stimulus of the debug module without a physical JTAG cable.

Parameters:
- TCK_DIV, 2, TCK half-period in clk cycles (legal 1..255).
- DR_WIDTH, 38, data-register shift length in bits (matches jdo/sr width).
- IR_WIDTH, 2, virtual instruction width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_ir  in  IR_WIDTH  instruction for vji_ir_in.
- cmd_data  in  DR_WIDTH  payload shifted out on vji_tdi, LSB first.
- rsp_valid  out  1  single-cycle pulse; rsp_data valid in the same cycle.
- rsp_data  out  DR_WIDTH  captured TDO bits; first bit captured lands in the LSB.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to the debug module.
- vji_tdo  in  1  serial data from the debug module.
- vji_ir_in  out  IR_WIDTH  virtual IR value.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state flags.

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (reset).
- Reset values: all outputs are 0, including cmd_ready while reset is high. State is IDLE and the divider counter is 0.
- Reset mid-operation: aborts immediately on the next clk edge; no rsp_valid is produced.
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RSP.
- TCK timing:
  - vji_tck is held low in IDLE and RSP.
  - In the other states it toggles every TCK_DIV clk cycles, starting low.
  - One TCK period is 2*TCK_DIV clk cycles.
- Output and sampling edges:
  - All vji_* outputs and state transitions update only at TCK falling edges (the clk cycle in which vji_tck goes 1->0), or on entry from IDLE.
  - vji_tdo is sampled on the clk cycle in which vji_tck goes 0->1.
- Command accept (IDLE, cmd_valid=1):
  - Latch cmd_ir and cmd_data into a DR_WIDTH shift register.
  - Next cycle: enter UIR with vji_tck=0.
- UIR: vji_uir=1 and vji_ir_in=cmd_ir for 1 TCK period. vji_ir_in then holds its value until the next command or reset.
- CDR: vji_cdr=1 for 1 TCK period.
- SDR: vji_sdr=1 for exactly DR_WIDTH TCK periods.
  - vji_tdi = shift[0].
  - At each rising edge, tdo is captured into a capture register as {tdo, cap[DR_WIDTH-1:1]}.
  - At each falling edge, the shift register shifts right.
  - A 6-bit bit counter runs 0..DR_WIDTH-1. Leave SDR after the falling edge that follows bit DR_WIDTH-1.
- UDR: vji_udr=1 for 1 period.
- RTI: vji_rti=1 for 1 period.
- RSP: rsp_valid=1 for one clk with rsp_data=cap. Next cycle: IDLE, cmd_ready=1.
- Flag rules:
  - At most one of uir/cdr/sdr/udr/rti is high at any time.
  - vji_tdi=0 outside SDR.
- Latency: with no IR skip, rsp_valid occurs 1 + 2*TCK_DIV*(DR_WIDTH+4) clk cycles after the accept cycle. The defaults give 169.
- Back-to-back commands: cmd_ready is low from the accept cycle through RSP. The earliest next accept is the cycle after RSP.
- rsp_data holds its value until the next RSP. There is no response backpressure.

Optional Feature:
- MONTRE_DE1_JTAG_IR_SKIP_EN defined:
  - The last issued IR is kept in a register with a valid bit; the valid bit is cleared by reset.
  - If cmd_ir equals the cached value, UIR is skipped (IDLE->CDR), and latency drops by 2*TCK_DIV.
- Not defined: every command includes UIR.

Decomposition:
- Package montre_de1_jtag_pkg holds:
  - state enum;
  - DR_WIDTH/IR_WIDTH defaults;
  - debug-module instruction encodings: OCIMEM=2'b00, TRACEMEM=2'b01, BREAK=2'b10, TRACECTRL=2'b11.
- One sub-module, montre_de1_jtag_tck_gen:
  - contains the divider counter;
  - outputs vji_tck plus the one-clk tck_rise/tck_fall strobes;
  - is enabled by the FSM.

Test Plan:
- Reset held 5 cycles mid-SDR (bit 10) -> all outputs 0 next cycle; cmd_ready=1 after release; no rsp_valid.
- TCK_DIV=2, cmd_ir=2'b10, cmd_data=38'h2A_5A5A_5A5A, loopback model (tdo = tdi delayed one TCK) -> uir pulse with ir_in=2'b10; 38 sdr periods; tdi sequence LSB-first 0,1,0,1,1,0,1,0...; rsp_valid at cycle 169 after accept.
- Stub responder returns a fixed sr 38'h3F_0000_0001 -> rsp_data=38'h3F_0000_0001; exactly one rsp_valid pulse.
- cmd_valid held high continuously, 3 commands -> accepts spaced exactly 170 cycles apart; cmd_ready low throughout each transaction.
- Check every clk cycle -> vji_* flags one-hot or zero; vji_tck low in IDLE; vji_tdi changes only on tck falling edges.
- MONTRE_DE1_JTAG_IR_SKIP_EN on, two commands with ir=2'b01 -> second command has no uir and rsp latency of 165 cycles; then ir=2'b00 -> uir present.
